// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC register, one-hot instruction decode, next-PC
// selection, BOOT/RUN/HALT sequencing, fault capture and retire counting.
module fetch_decode #(
    parameter logic [31:0] RESET_PC        = 32'h0040_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [30:0] op,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  fault_q, fault_d;
    logic [30:0] dec;
    logic        illegal;
    logic [31:0] next_pc;
    logic [31:0] br_off;

    assign instr     = imem_data;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;
    assign retired   = retired_q;

    always_comb begin
        dec = '0;
        case (imem_data[31:26])
            6'h00: begin
                case (imem_data[5:0])
                    6'h21: dec[0]  = 1'b1;
                    6'h20: dec[1]  = 1'b1;
                    6'h23: dec[2]  = 1'b1;
                    6'h22: dec[3]  = 1'b1;
                    6'h24: dec[4]  = 1'b1;
                    6'h25: dec[5]  = 1'b1;
                    6'h26: dec[6]  = 1'b1;
                    6'h27: dec[7]  = 1'b1;
                    6'h00: dec[8]  = 1'b1;
                    6'h02: dec[9]  = 1'b1;
                    6'h03: dec[10] = 1'b1;
                    6'h2A: dec[11] = 1'b1;
                    6'h2B: dec[12] = 1'b1;
                    6'h04: dec[13] = 1'b1;
                    6'h06: dec[14] = 1'b1;
                    6'h07: dec[15] = 1'b1;
                    6'h08: dec[30] = 1'b1;
                    default: dec = '0;
                endcase
            end
            6'h08: dec[16] = 1'b1;
            6'h09: dec[17] = 1'b1;
            6'h0C: dec[18] = 1'b1;
            6'h0D: dec[19] = 1'b1;
            6'h0E: dec[20] = 1'b1;
            6'h0A: dec[21] = 1'b1;
            6'h0B: dec[22] = 1'b1;
            6'h0F: dec[23] = 1'b1;
            6'h23: dec[24] = 1'b1;
            6'h2B: dec[25] = 1'b1;
            6'h05: dec[26] = 1'b1;
            6'h04: dec[27] = 1'b1;
            6'h02: dec[28] = 1'b1;
            6'h03: dec[29] = 1'b1;
            default: dec = '0;
        endcase
    end

    assign illegal = ~|dec;
    assign br_off  = {{14{imem_data[15]}}, imem_data[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (dec[30])
            next_pc = rs_data;
        else if (dec[28] | dec[29])
            next_pc = {pc_plus4[31:28], imem_data[25:0], 2'b00};
        else if ((dec[26] & ~zero) | (dec[27] & zero))
            next_pc = pc_plus4 + br_off;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        op        = '0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (stall) begin
                    state_d = RUN;
                end else if (illegal) begin
                    if (HALT_ON_ILLEGAL) begin
                        fault_d = (fault_q == 2'b00) ? 2'b01 : fault_q;
                        state_d = HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (dec[30] && (rs_data[1:0] != 2'b00)) begin
                    // jr still shows on op so downstream sees the faulting instr
                    op      = dec;
                    fault_d = (fault_q == 2'b00) ? 2'b10 : fault_q;
                    state_d = HALT;
                end else begin
                    op        = dec;
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            fault_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: stimulus pushes expected outputs from
// a rule-level model; a negedge monitor pops and compares.
module tb_fetch_decode;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] imem_data = '0;
    logic [31:0] imem_addr, pc, pc_plus4, instr, retired;
    logic [30:0] op;
    logic        halted;
    logic [1:0]  fault;

    always #5 clk = ~clk;

    fetch_decode dut (
        .clk(clk), .rst(rst), .stall(stall), .zero(zero),
        .rs_data(rs_data), .imem_data(imem_data),
        .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .op(op), .halted(halted), .fault(fault),
        .retired(retired)
    );

    typedef struct {
        logic [30:0] op;
        logic [31:0] pc;
        logic [31:0] pp4;
        logic [31:0] instr;
        logic        halted;
        logic [1:0]  fault;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int OPC[31] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h08, 8'h09, 8'h0C, 8'h0D, 8'h0E, 8'h0A, 8'h0B, 8'h0F,
                    8'h23, 8'h2B, 8'h05, 8'h04, 8'h02, 8'h03, 8'h00};
    int FUN[31] = '{8'h21, 8'h20, 8'h23, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27,
                    8'h00, 8'h02, 8'h03, 8'h2A, 8'h2B, 8'h04, 8'h06, 8'h07,
                    -1, -1, -1, -1, -1, -1, -1, -1,
                    -1, -1, -1, -1, -1, -1, 8'h08};

    // model state: 0 boot, 1 run, 2 halt
    int          mst = 0;
    logic [31:0] mpc = RPC;
    logic [31:0] mret = '0;
    logic [1:0]  mflt = '0;

    function automatic int decode(input logic [31:0] w);
        int opc = int'(w[31:26]);
        int fn  = int'(w[5:0]);
        for (int i = 0; i < 31; i++)
            if (opc == OPC[i] && (OPC[i] != 0 || fn == FUN[i]))
                return i;
        return -1;
    endfunction

    function automatic logic [31:0] mk(input int idx);
        logic [31:0] w = $urandom;
        w[31:26] = 6'(OPC[idx]);
        if (OPC[idx] == 0) w[5:0] = 6'(FUN[idx]);
        return w;
    endfunction

    task automatic step(input logic r, input logic s, input logic z,
                        input logic [31:0] w, input logic [31:0] rs);
        exp_t        e;
        int          idx;
        logic [31:0] p4, tgt;
        @(posedge clk);
        #1;
        rst = r; stall = s; zero = z; imem_data = w; rs_data = rs;
        if (r) begin
            mst = 0; mpc = RPC; mret = '0; mflt = '0;
        end
        p4       = mpc + 32'd4;
        e.op     = '0;
        e.pc     = mpc;
        e.pp4    = p4;
        e.instr  = w;
        e.halted = (mst == 2);
        e.fault  = mflt;
        e.ret    = mret;
        idx      = decode(w);
        if (!r) begin
            if (mst == 0) begin
                mst = 1;
            end else if (mst == 1 && !s) begin
                if (idx < 0) begin
                    if (mflt == 0) mflt = 2'b01;
                    mst = 2;
                end else begin
                    e.op = 31'(1) << idx;
                    if (idx == 30 && rs[1:0] != 0) begin
                        if (mflt == 0) mflt = 2'b10;
                        mst = 2;
                    end else begin
                        if (idx == 30) tgt = rs;
                        else if (idx == 28 || idx == 29)
                            tgt = {p4[31:28], w[25:0], 2'b00};
                        else if ((idx == 26 && !z) || (idx == 27 && z))
                            tgt = p4 + 32'($signed(w[15:0])) * 32'd4;
                        else tgt = p4;
                        mpc  = tgt;
                        mret = mret + 1;
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("op", 32'(op), 32'(e.op));
            chk("pc", pc, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("pc_plus4", pc_plus4, e.pp4);
            chk("instr", instr, e.instr);
            chk("halted", 32'(halted), 32'(e.halted));
            chk("fault", 32'(fault), 32'(e.fault));
            chk("retired", retired, e.ret);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hc = 0;
        int k;
        logic [31:0] w, rs;
        step(1, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0085_1021, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0085_1021, 32'h0);
        step(0, 0, 1, 32'h1000_0003, 32'h0);
        step(0, 0, 0, 32'h1000_0003, 32'h0);
        step(0, 0, 0, 32'h0C10_0008, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0085_1021, 32'h0);
        step(0, 0, 0, 32'h0085_1021, 32'h0);
        step(0, 0, 0, 32'h03E0_0008, 32'h0040_0006);
        step(0, 0, 0, 32'h0085_1021, 32'h0);
        step(0, 0, 0, 32'h0085_1021, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0085_1021, 32'h0);
        step(0, 0, 0, 32'hFC00_0000, 32'h0);
        step(0, 0, 0, 32'h0085_1021, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            if (mst == 2) hc++;
            if (hc >= 2) begin
                hc = 0;
                step(1, 0, 0, $urandom, $urandom);
            end else begin
                k = int'($urandom_range(0, 99));
                if (k < 6) w = $urandom;
                else w = mk(int'($urandom_range(0, 30)));
                rs = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
                step(0, ($urandom_range(0, 99) < 15), 1'($urandom), w, rs);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
